pll_lock_sequencer: RTL and testbench

Reset and lock sequencer for the core PLL (50 MHz reference, 12/24 MHz outputs). Runs on the reference clock and holds the PLL in reset for a fixed pulse after power-up. It then waits for a stable `locked`, retries on timeout, and only then releases the core reset. It also handles loss of lock while running, so downstream clock domains never leave reset on an unlocked PLL.

---
 rtl/pll_lock_sequencer.sv | 142 ++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses pll_rst, waits for a stable synchronized lock with retries, then releases core_rst.
// Optional macro PLL_SEQ_AUTORECOVER_EN: lock loss in RUN re-pulses the PLL reset instead of only re-waiting for lock.
module pll_lock_sequencer #(
    parameter int RST_CYCLES     = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRY      = 3,
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic          refclk,
    input  logic          rst,
    input  logic          pll_locked,
    input  logic          reinit,
    output logic          pll_rst,
    output logic          core_rst,
    output logic          ready,
    output logic          fail,
    output logic          lock_lost,
    output logic [RW-1:0] retry_cnt
);

    localparam int MAX_A   = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
    localparam int MAX_CNT = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic             lost_q, lost_d;
    logic [1:0]       sync_q;
    logic             lock_s;
    logic             pll_rst_q, pll_rst_d;
    logic             core_rst_q, core_rst_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;

    assign lock_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        lost_d  = lost_q;
        if (reinit) begin
            state_d = S_RESET_PLL;
            retry_d = '0;
            lost_d  = 1'b0;
        end else begin
            case (state_q)
                S_RESET_PLL: begin
                    if (cnt_q == CNT_W'(RST_CYCLES - 1))
                        state_d = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    // Timeout has priority over a lock arriving in the same cycle.
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        if (retry_q < RW'(MAX_RETRY)) begin
                            retry_d = retry_q + RW'(1);
                            state_d = S_RESET_PLL;
                        end else begin
                            state_d = S_FAIL;
                        end
                    end else if (lock_s) begin
                        state_d = S_STABLE;
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state_d = S_WAIT_LOCK;
                    end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                        state_d = S_RUN;
                        retry_d = '0;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        lost_d = 1'b1;
`ifdef PLL_SEQ_AUTORECOVER_EN
                        state_d = S_RESET_PLL;
`else
                        state_d = S_WAIT_LOCK;
`endif
                    end
                end
                S_FAIL:  state_d = S_FAIL;
                default: state_d = S_RESET_PLL;
            endcase
        end

        // The counter only runs in the timed states and restarts on any state change.
        if (reinit || (state_d != state_q))
            cnt_d = '0;
        else if ((state_q == S_RESET_PLL) || (state_q == S_WAIT_LOCK) || (state_q == S_STABLE))
            cnt_d = cnt_q + CNT_W'(1);
        else
            cnt_d = cnt_q;

        pll_rst_d  = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
        core_rst_d = (state_d != S_RUN);
        ready_d    = (state_d == S_RUN);
        fail_d     = (state_d == S_FAIL);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RESET_PLL;
            cnt_q      <= '0;
            retry_q    <= '0;
            lost_q     <= 1'b0;
            sync_q     <= 2'b00;
            pll_rst_q  <= 1'b1;
            core_rst_q <= 1'b1;
            ready_q    <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            lost_q     <= lost_d;
            sync_q     <= {sync_q[0], pll_locked};
            pll_rst_q  <= pll_rst_d;
            core_rst_q <= core_rst_d;
            ready_q    <= ready_d;
            fail_q     <= fail_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign core_rst  = core_rst_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign lock_lost = lost_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios plus random lock activity, checked each cycle against a countdown model.
module tb_pll_lock_sequencer;

    localparam int RC = 4;
    localparam int SC = 8;
    localparam int TC = 32;
    localparam int MR = 2;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STB  = 2;
    localparam int P_RUN  = 3;
    localparam int P_FAIL = 4;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       reinit;
    logic       pll_rst;
    logic       core_rst;
    logic       ready;
    logic       fail;
    logic       lock_lost;
    logic [1:0] retry_cnt;

    pll_lock_sequencer #(
        .RST_CYCLES    (RC),
        .STABLE_CYCLES (SC),
        .TIMEOUT_CYCLES(TC),
        .MAX_RETRY     (MR)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .reinit    (reinit),
        .pll_rst   (pll_rst),
        .core_rst  (core_rst),
        .ready     (ready),
        .fail      (fail),
        .lock_lost (lock_lost),
        .retry_cnt (retry_cnt)
    );

    always #5 refclk = ~refclk;

    int vectors = 0;
    int errors  = 0;

    // Reference model: phase plus cycles remaining in it, and the lock samples still in flight.
    int m_phase;
    int m_left;
    int m_retries;
    bit m_lost;
    bit lk_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase   = P_RST;
        m_left    = RC;
        m_retries = 0;
        m_lost    = 1'b0;
        lk_q      = {1'b0, 1'b0};
    endtask

    task automatic enter(input int ph, input int len);
        m_phase = ph;
        m_left  = len;
    endtask

    task automatic model_edge();
        bit lk;
        if (rst) begin
            model_reset();
            return;
        end
        lk = lk_q.pop_front();
        lk_q.push_back(pll_locked);
        if (reinit) begin
            enter(P_RST, RC);
            m_retries = 0;
            m_lost    = 1'b0;
            return;
        end
        case (m_phase)
            P_RST:  if (m_left == 1) enter(P_WAIT, TC); else m_left--;
            P_WAIT: begin
                if (m_left == 1) begin
                    if (m_retries < MR) begin
                        m_retries++;
                        enter(P_RST, RC);
                    end else begin
                        enter(P_FAIL, 0);
                    end
                end else if (lk) begin
                    enter(P_STB, SC);
                end else begin
                    m_left--;
                end
            end
            P_STB: begin
                if (!lk) enter(P_WAIT, TC);
                else if (m_left == 1) begin
                    enter(P_RUN, 0);
                    m_retries = 0;
                end else m_left--;
            end
            P_RUN: begin
                if (!lk) begin
                    m_lost = 1'b1;
`ifdef PLL_SEQ_AUTORECOVER_EN
                    enter(P_RST, RC);
`else
                    enter(P_WAIT, TC);
`endif
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_outputs(input string ctx);
        check({ctx, ".pll_rst"},   32'(pll_rst),   32'((m_phase == P_RST) || (m_phase == P_FAIL)));
        check({ctx, ".core_rst"},  32'(core_rst),  32'(m_phase != P_RUN));
        check({ctx, ".ready"},     32'(ready),     32'(m_phase == P_RUN));
        check({ctx, ".fail"},      32'(fail),      32'(m_phase == P_FAIL));
        check({ctx, ".lock_lost"}, 32'(lock_lost), 32'(m_lost));
        check({ctx, ".retry_cnt"}, 32'(retry_cnt), 32'(m_retries));
    endtask

    task automatic check_reset_values(input string ctx);
        check({ctx, ".pll_rst"},   32'(pll_rst),   32'd1);
        check({ctx, ".core_rst"},  32'(core_rst),  32'd1);
        check({ctx, ".ready"},     32'(ready),     32'd0);
        check({ctx, ".fail"},      32'(fail),      32'd0);
        check({ctx, ".lock_lost"}, 32'(lock_lost), 32'd0);
        check({ctx, ".retry_cnt"}, 32'(retry_cnt), 32'd0);
    endtask

    task automatic step();
        @(posedge refclk);
        #1;
        model_edge();
        check_outputs("cyc");
    endtask

    int n;
    int pr_cnt;
    int hold;

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
        reinit     = 1'b0;
        repeat (3) @(posedge refclk);
        #1;
        model_reset();
        check_reset_values("reset");
        rst = 1'b0;

        // Power-up with lock arriving 10 cycles after reset release.
        pr_cnt = pll_rst ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (pll_rst) pr_cnt++;
        end
        check("powerup_pll_rst_cycles", 32'(pr_cnt), 32'(RC));
        pll_locked = 1'b1;
        n = 0;
        do begin step(); n++; end while (ready !== 1'b1 && n < 200);
        check("powerup_lock_latency", 32'(n), 32'(SC + 3));
        check("powerup_retry_cnt", 32'(retry_cnt), 32'd0);

        // Lock drop while running.
        repeat (5) step();
        pll_locked = 1'b0;
        n = 0;
        do begin step(); n++; end while (core_rst !== 1'b1 && n < 20);
        check("runloss_core_rst_delay", 32'(n), 32'd3);
        check("runloss_lock_lost", 32'(lock_lost), 32'd1);
`ifndef PLL_SEQ_AUTORECOVER_EN
        check("runloss_pll_rst", 32'(pll_rst), 32'd0);
`endif
        pll_locked = 1'b1;
        n = 0;
        do begin step(); n++; end while (ready !== 1'b1 && n < 200);
`ifndef PLL_SEQ_AUTORECOVER_EN
        check("relock_latency", 32'(n), 32'(SC + 3));
`endif
        check("relock_lock_lost_sticky", 32'(lock_lost), 32'd1);

        // Reinit, then a 2-cycle glitch while in STABLE.
        pll_locked = 1'b0;
        reinit     = 1'b1;
        step();
        reinit = 1'b0;
        check("reinit_lock_lost_clear", 32'(lock_lost), 32'd0);
        check("reinit_pll_rst", 32'(pll_rst), 32'd1);
        n = 0;
        while (m_phase != P_WAIT && n < 50) begin step(); n++; end
        pll_locked = 1'b1;
        repeat (5) step();
        pll_locked = 1'b0;
        repeat (2) step();
        pll_locked = 1'b1;
        n = 0;
        do begin step(); n++; end while (ready !== 1'b1 && n < 200);
        check("glitch_relock_latency", 32'(n), 32'(SC + 3));

        // Asynchronous reset in the middle of STABLE.
        reinit = 1'b1;
        step();
        reinit = 1'b0;
        n = 0;
        while (!(m_phase == P_STB && m_left == SC - 2) && n < 100) begin step(); n++; end
        #3 rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        model_reset();
        repeat (2) step();
        pll_locked = 1'b0;
        rst        = 1'b0;

        // No lock at all: every retry times out, then FAIL.
        n = 0;
        do begin step(); n++; end while (fail !== 1'b1 && n < 400);
        check("fail_cycles", 32'(n), 32'((MR + 1) * (RC + TC)));
        check("fail_retry_cnt", 32'(retry_cnt), 32'(MR));
        check("fail_pll_rst", 32'(pll_rst), 32'd1);
        repeat (5) step();
        reinit = 1'b1;
        step();
        reinit = 1'b0;
        check("fail_reinit_fail", 32'(fail), 32'd0);
        check("fail_reinit_retry", 32'(retry_cnt), 32'd0);
        check("fail_reinit_pll_rst", 32'(pll_rst), 32'd1);

        // Reinit coinciding with the second WAIT_LOCK timeout.
        n = 0;
        while (!(m_phase == P_WAIT && m_left == 1 && m_retries == 1) && n < 200) begin step(); n++; end
        check("timeout_retry_before", 32'(retry_cnt), 32'd1);
        reinit = 1'b1;
        step();
        reinit = 1'b0;
        check("timeout_reinit_retry", 32'(retry_cnt), 32'd0);
        check("timeout_reinit_pll_rst", 32'(pll_rst), 32'd1);

        // Random lock activity with occasional reinit requests.
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                pll_locked = ($urandom_range(0, 3) != 0);
                hold       = $urandom_range(1, 40);
            end
            hold--;
            reinit = ($urandom_range(0, 99) == 0);
            step();
        end
        reinit = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
